// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream packet arbiter.
// Build option: AXIS_PACKET_ARBITER_STRICT_PRIO_EN selects fixed priority instead of round-robin.
package axis_packet_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Last-grant pointer resets to NUM_SRC - 1 so the first pick after reset is source 0.
    localparam int LAST_GRANT_RST_OFFSET = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_picker.sv
// Combinational request picker: round-robin from last_grant + 1, or lowest index
// when AXIS_PACKET_ARBITER_STRICT_PRIO_EN is defined.
module pkt_rr_picker
    import axis_packet_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int SEL_WIDTH = 3
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SEL_WIDTH-1:0] last_grant,
    output logic                 pick_valid,
    output logic [SEL_WIDTH-1:0] pick
);

`ifdef AXIS_PACKET_ARBITER_STRICT_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
`endif

    // Each requester gets a distance from the search start; the smallest distance wins.
    always_comb begin
        int best;
        int d;
        pick_valid = 1'b0;
        pick       = '0;
        best       = NUM_SRC;
        d          = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
`ifdef AXIS_PACKET_ARBITER_STRICT_PRIO_EN
            d = j;
`else
            d = j - int'(last_grant) - 1;
            if (d < 0) begin
                d = d + NUM_SRC;
            end
`endif
            if (req[j] && (d < best)) begin
                best       = d;
                pick       = SEL_WIDTH'(j);
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet arbiter sharing one AXI4-Stream master between NUM_SRC slave streams.
// Build option: AXIS_PACKET_ARBITER_STRICT_PRIO_EN (fixed priority, source 0 highest).
module axis_packet_arbiter
    import axis_packet_arbiter_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32,
    parameter int NUM_SRC          = 2,
    parameter int SEL_WIDTH        = 3
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [CNTR_WIDTH-1:0]           cfg_data,
    input  logic [NUM_SRC-1:0]              cfg_mask,
    input  logic [NUM_SRC*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    input  logic                            m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [SEL_WIDTH-1:0]            m_axis_tdest,
    output logic [31:0]                     sts_pkt_cntr
);

    localparam logic [SEL_WIDTH-1:0] LAST_GRANT_RST = SEL_WIDTH'(NUM_SRC - LAST_GRANT_RST_OFFSET);

    if ((NUM_SRC < 2) || (NUM_SRC > 8)) begin : g_bad_num_src
        $error("axis_packet_arbiter: NUM_SRC must be in 2..8");
    end
    if (SEL_WIDTH < clog2(NUM_SRC)) begin : g_bad_sel_width
        $error("axis_packet_arbiter: SEL_WIDTH too small for NUM_SRC");
    end

    state_t                     state_reg;
    state_t                     state_next;
    logic [SEL_WIDTH-1:0]       grant_reg;
    logic [SEL_WIDTH-1:0]       last_grant_reg;
    logic [CNTR_WIDTH-1:0]      beat_cnt_reg;
    logic [CNTR_WIDTH-1:0]      len_reg;
    logic [31:0]                pkt_cntr_reg;

    logic [NUM_SRC-1:0]         candidates;
    logic                       pick_valid;
    logic [SEL_WIDTH-1:0]       pick;
    logic [NUM_SRC-1:0]         grant_hit;
    logic [AXIS_TDATA_WIDTH-1:0] src_word [NUM_SRC];
    logic                       granted_valid;
    logic                       is_last;
    logic                       handshake;

    assign candidates = cfg_mask & s_axis_tvalid;

    pkt_rr_picker #(
        .NUM_SRC   (NUM_SRC),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_picker (
        .req        (candidates),
        .last_grant (last_grant_reg),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // One-hot view of the grant and per-source data words keep the muxes index-width clean.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign grant_hit[gi] = (grant_reg == SEL_WIDTH'(gi));
        assign src_word[gi]  = s_axis_tdata[gi*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
    end

    assign granted_valid = |(s_axis_tvalid & grant_hit);
    assign is_last       = (beat_cnt_reg == len_reg);
    assign handshake     = (state_reg == XFER) && granted_valid && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (handshake && is_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Length and source are latched only when a packet starts; mid-packet cfg changes wait.
    always_ff @(posedge aclk) begin
        if (areset) begin
            grant_reg      <= '0;
            last_grant_reg <= LAST_GRANT_RST;
            beat_cnt_reg   <= '0;
            len_reg        <= '0;
            pkt_cntr_reg   <= '0;
        end else begin
            if ((state_reg == IDLE) && pick_valid) begin
                grant_reg      <= pick;
                last_grant_reg <= pick;
                len_reg        <= cfg_data;
                beat_cnt_reg   <= '0;
            end
            if (handshake) begin
                if (is_last) begin
                    pkt_cntr_reg <= pkt_cntr_reg + 32'd1;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdest  = '0;
        if (state_reg == XFER) begin
            s_axis_tready = grant_hit & {NUM_SRC{m_axis_tready}};
            m_axis_tvalid = granted_valid;
            m_axis_tlast  = is_last;
            m_axis_tdest  = grant_reg;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_hit[i]) begin
                    m_axis_tdata = src_word[i];
                end
            end
        end
    end

    assign sts_pkt_cntr = pkt_cntr_reg;

endmodule
